// File: rtl/port_receiver.sv
// Switch input port: four-phase req/ack receiver that stores one flit per
// handshake into a small FIFO and presents the head flit with its destination.
module port_receiver #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 4,
    parameter int DEST_LSB   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_req,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ack,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [2:0]              out_dest,
    input  logic                    out_pop,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    o_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Upstream: four-phase. A flit is taken on the edge where in_req is 1,
    // state is IDLE and the FIFO is not full; in_ack then stays high until
    // in_req has been seen low. Downstream: out_valid/out_pop, a pop takes
    // effect only on an edge where out_valid is 1.
    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_req;
    logic                    w_write;
    logic                    w_pop;
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    // An undriven (X/Z) request line must read as "no request".
    assign w_req = (in_req === 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_write      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req && !full) begin
                    w_write      = 1'b1;
                    w_next_state = ACKED;
                end
            end
            ACKED: begin
                if (!w_req) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_pop = out_pop && out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_write) - CW'(w_pop);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign in_ack      = (r_state == ACKED);
    assign o_dbg_state = r_state;
    assign count       = r_count;
    assign full        = (r_count == CW'(DEPTH));
    assign out_valid   = (r_count != '0);
    assign out_data    = r_mem[r_rd_ptr];
    assign out_dest    = out_data[DEST_LSB+2:DEST_LSB];

endmodule

// File: tb/tb_port_receiver.sv
// Directed bench for port_receiver: handshake, fill/backpressure, ordering
// with wrap, simultaneous write/pop, floating request and async reset.
module tb_port_receiver;

    logic        clk;
    logic        rst_n;
    logic        in_req;
    logic [17:0] in_data;
    logic        in_ack;
    logic        out_valid;
    logic [17:0] out_data;
    logic [2:0]  out_dest;
    logic        out_pop;
    logic [2:0]  count;
    logic        full;
    logic        o_dbg_state;

    int checks = 0;
    int errors = 0;

    port_receiver #(
        .DATA_WIDTH(18),
        .DEPTH     (4),
        .DEST_LSB  (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_req     (in_req),
        .in_data    (in_data),
        .in_ack     (in_ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_dest   (out_dest),
        .out_pop    (out_pop),
        .count      (count),
        .full       (full),
        .o_dbg_state(o_dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: full four-phase handshake, returns at a falling edge with
    // in_req and in_ack both low. A stuck handshake is reported, not hung on.
    task automatic send_flit(input logic [17:0] d);
        int n;
        @(negedge clk);
        in_data = d;
        in_req  = 1'b1;
        n = 0;
        while (in_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ack !== 1'b1) begin
            errors++;
            $display("FAIL send_ack data=%h in_ack=%b expected 1", d, in_ack);
        end
        in_req = 1'b0;
        n = 0;
        while (in_ack !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ack !== 1'b0) begin
            errors++;
            $display("FAIL send_release data=%h in_ack=%b expected 0", d, in_ack);
        end
    endtask

    // Driver: observe head at a falling edge, pop it, return one cycle later.
    task automatic do_pop(output logic [17:0] head, output logic [2:0] dest,
                          output logic valid);
        head    = out_data;
        dest    = out_dest;
        valid   = out_valid;
        out_pop = 1'b1;
        @(negedge clk);
        out_pop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        in_req  = 1'b0;
        in_data = '0;
        out_pop = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ack !== 1'b0 || out_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0
            || o_dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL reset ack=%b valid=%b count=%0d full=%b st=%b expected 0/0/0/0/0",
                     in_ack, out_valid, count, full, o_dbg_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_flit();
        logic [17:0] h;
        logic [2:0]  d;
        logic        v;
        @(negedge clk);
        in_data = 18'h00005;
        in_req  = 1'b1;
        checks++;
        if (in_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_pre_ack got=%b expected 0", in_ack);
        end
        @(negedge clk);
        checks++;
        if (in_ack !== 1'b1 || out_valid !== 1'b1 || out_dest !== 3'd5
            || out_data !== 18'h00005 || count !== 3'd1 || o_dbg_state !== 1'b1) begin
            errors++;
            $display("FAIL single_ack ack=%b valid=%b dest=%0d data=%h count=%0d st=%b expected 1/1/5/00005/1/1",
                     in_ack, out_valid, out_dest, out_data, count, o_dbg_state);
        end
        // Holding in_req must not write a second copy.
        @(negedge clk);
        checks++;
        if (in_ack !== 1'b1 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_hold ack=%b count=%0d expected 1/1", in_ack, count);
        end
        in_req = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ack !== 1'b0 || o_dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL single_release ack=%b st=%b expected 0/0", in_ack, o_dbg_state);
        end
        do_pop(h, d, v);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain count=%0d valid=%b expected 0/0", count, out_valid);
        end
        // Pops while empty are ignored: no underflow.
        out_pop = 1'b1;
        repeat (2) @(negedge clk);
        out_pop = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_pop count=%0d valid=%b expected 0/0", count, out_valid);
        end
    endtask

    task automatic test_fill();
        logic [17:0] h;
        logic [2:0]  d;
        logic        v;
        logic        ack_seen;
        logic [17:0] exp_vals [4];
        exp_vals[0] = 18'h00012;
        exp_vals[1] = 18'h00013;
        exp_vals[2] = 18'h00014;
        exp_vals[3] = 18'h00015;
        send_flit(18'h00011);
        send_flit(18'h00012);
        send_flit(18'h00013);
        send_flit(18'h00014);
        checks++;
        if (count !== 3'd4 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill_full count=%0d full=%b expected 4/1", count, full);
        end
        in_data  = 18'h00015;
        in_req   = 1'b1;
        ack_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (in_ack !== 1'b0) ack_seen = 1'b1;
        end
        checks++;
        if (ack_seen !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL fill_blocked ack_seen=%b count=%0d expected 0/4", ack_seen, count);
        end
        // Pop while full with in_req high: no write on that same edge.
        out_pop = 1'b1;
        @(negedge clk);
        out_pop = 1'b0;
        checks++;
        if (count !== 3'd3 || in_ack !== 1'b0) begin
            errors++;
            $display("FAIL fill_pop_edge count=%0d ack=%b expected 3/0", count, in_ack);
        end
        @(negedge clk);
        checks++;
        if (count !== 3'd4 || in_ack !== 1'b1 || out_data !== 18'h00012) begin
            errors++;
            $display("FAIL fill_admit count=%0d ack=%b head=%h expected 4/1/00012",
                     count, in_ack, out_data);
        end
        in_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            do_pop(h, d, v);
            checks++;
            if (v !== 1'b1 || h !== exp_vals[i]) begin
                errors++;
                $display("FAIL fill_drain[%0d] valid=%b data=%h expected 1/%h", i, v, h, exp_vals[i]);
            end
        end
        checks++;
        if (count !== 3'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty count=%0d full=%b expected 0/0", count, full);
        end
    endtask

    task automatic test_order_wrap();
        logic [17:0] exp_q[$];
        logic [17:0] e;
        logic [17:0] h;
        logic [2:0]  d;
        logic        v;
        int          k;
        int          got;
        got = 0;
        for (int i = 1; i <= 10; i++) begin
            if (exp_q.size() == 4) begin
                e = exp_q.pop_front();
                do_pop(h, d, v);
                got++;
                checks++;
                if (v !== 1'b1 || h !== e || d !== e[2:0]) begin
                    errors++;
                    $display("FAIL order_pop valid=%b data=%h dest=%0d expected 1/%h/%0d", v, h, d, e, e[2:0]);
                end
            end
            send_flit(18'(i));
            exp_q.push_back(18'(i));
            checks++;
            if (count !== 3'(exp_q.size())) begin
                errors++;
                $display("FAIL order_count got=%0d expected %0d", count, exp_q.size());
            end
            k = $urandom_range(0, exp_q.size());
            repeat (k) begin
                e = exp_q.pop_front();
                do_pop(h, d, v);
                got++;
                checks++;
                if (v !== 1'b1 || h !== e || d !== e[2:0]) begin
                    errors++;
                    $display("FAIL order_pop valid=%b data=%h dest=%0d expected 1/%h/%0d", v, h, d, e, e[2:0]);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            do_pop(h, d, v);
            got++;
            checks++;
            if (v !== 1'b1 || h !== e || d !== e[2:0]) begin
                errors++;
                $display("FAIL order_pop valid=%b data=%h dest=%0d expected 1/%h/%0d", v, h, d, e, e[2:0]);
            end
        end
        checks++;
        if (got != 10 || out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL order_total got=%0d valid=%b count=%0d expected 10/0/0", got, out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] h;
        logic [2:0]  d;
        logic        v;
        send_flit(18'h00021);
        send_flit(18'h00022);
        in_data = 18'h00023;
        in_req  = 1'b1;
        out_pop = 1'b1;
        @(negedge clk);
        out_pop = 1'b0;
        checks++;
        if (count !== 3'd2 || out_data !== 18'h00022 || in_ack !== 1'b1) begin
            errors++;
            $display("FAIL simul count=%0d head=%h ack=%b expected 2/00022/1", count, out_data, in_ack);
        end
        in_req = 1'b0;
        @(negedge clk);
        do_pop(h, d, v);
        do_pop(h, d, v);
        checks++;
        if (v !== 1'b1 || h !== 18'h00023 || count !== 3'd0) begin
            errors++;
            $display("FAIL simul_tail valid=%b data=%h count=%0d expected 1/00023/0", v, h, count);
        end
    endtask

    task automatic test_req_floating();
        logic bad;
        bad    = 1'b0;
        in_req = 1'bz;
        repeat (20) begin
            @(negedge clk);
            if (in_ack !== 1'b0 || count !== 3'd0) bad = 1'b1;
        end
        in_req = 1'bx;
        repeat (5) begin
            @(negedge clk);
            if (in_ack !== 1'b0 || count !== 3'd0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || in_ack !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL req_float bad=%b ack=%b count=%0d expected 0/0/0", bad, in_ack, count);
        end
        in_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_acked();
        logic [17:0] h;
        logic [2:0]  d;
        logic        v;
        send_flit(18'h00031);
        send_flit(18'h00032);
        @(negedge clk);
        in_data = 18'h00033;
        in_req  = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ack !== 1'b1 || count !== 3'd3) begin
            errors++;
            $display("FAIL rst_setup ack=%b count=%0d expected 1/3", in_ack, count);
        end
        // Mid-low-phase: no rising edge between reset assertion and the check.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ack !== 1'b0 || count !== 3'd0 || out_valid !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL rst_async ack=%b count=%0d valid=%b full=%b expected 0/0/0/0",
                     in_ack, count, out_valid, full);
        end
        in_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_flit(18'h0003f);
        checks++;
        if (count !== 3'd1 || out_data !== 18'h0003f || out_dest !== 3'd7) begin
            errors++;
            $display("FAIL rst_after count=%0d head=%h dest=%0d expected 1/0003f/7", count, out_data, out_dest);
        end
        do_pop(h, d, v);
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_fill();
        test_order_wrap();
        test_back_to_back();
        test_req_floating();
        test_reset_acked();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
